// File: rtl/i_serdes_word_aligner.sv
// Serial-to-parallel word aligner: deserializes D into WIDTH-bit words and
// bit-slips the word boundary until TRAIN_PATTERN repeats LOCK_COUNT times.
module i_serdes_word_aligner #(
  parameter int                WIDTH         = 4,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = 4'b0011,
  parameter int                LOCK_COUNT    = 4
) (
  input  logic             PLL_CLK,
  input  logic             RST,
  input  logic             D,
  input  logic             D_EN,
  input  logic             ALIGN_EN,
  input  logic             RELOCK,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic             LOCKED,
  output logic             ALIGN_ERR
);

  // state | meaning
  // HUNT  | searching for the pattern, slipping one bit per mismatch
  // CHECK | pattern seen, counting consecutive matches
  // LOCK  | aligned, no compares until RELOCK
  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [SW-1:0] SLIP_LAST  = SW'(WIDTH - 1);
  localparam logic [3:0]    MATCH_LAST = 4'(LOCK_COUNT - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             slip_pend_q, slip_pend_d;
  logic [SW-1:0]    slip_cnt_q, slip_cnt_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             locked_q, locked_d;
  logic             align_err_q, align_err_d;

  logic [WIDTH-1:0] nw;
  logic             word_done;
  logic             is_match;

  assign nw        = {sr_q[WIDTH-2:0], D};
  assign word_done = D_EN && !slip_pend_q && (cnt_q == CNT_LAST);
  assign is_match  = (nw == TRAIN_PATTERN);

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    slip_pend_d = slip_pend_q;
    slip_cnt_d  = slip_cnt_q;
    match_cnt_d = match_cnt_q;
    state_d     = state_q;
    q_d         = q_q;
    q_valid_d   = 1'b0;
    locked_d    = locked_q;
    align_err_d = 1'b0;

    // A pending slip swallows one bit into sr without advancing cnt.
    if (D_EN) begin
      sr_d = nw;
      if (slip_pend_q) begin
        slip_pend_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (word_done) begin
      q_d       = nw;
      q_valid_d = 1'b1;
    end

    if (RELOCK) begin
      state_d     = ST_HUNT;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      slip_cnt_d  = '0;
      slip_pend_d = 1'b0;
    end else if (word_done && ALIGN_EN) begin
      case (state_q)
        ST_HUNT: begin
          if (is_match) begin
            match_cnt_d = 4'd1;
            slip_cnt_d  = '0;
            if (LOCK_COUNT == 1) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            slip_pend_d = 1'b1;
            if (slip_cnt_q == SLIP_LAST) begin
              align_err_d = 1'b1;
              slip_cnt_d  = '0;
            end else begin
              slip_cnt_d = slip_cnt_q + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (is_match) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q == MATCH_LAST) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end
          end else begin
            state_d     = ST_HUNT;
            match_cnt_d = '0;
            slip_pend_d = 1'b1;
            slip_cnt_d  = SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PLL_CLK or negedge RST) begin
    if (!RST) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
      slip_cnt_q  <= '0;
      match_cnt_q <= '0;
      state_q     <= ST_HUNT;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      locked_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      slip_pend_q <= slip_pend_d;
      slip_cnt_q  <= slip_cnt_d;
      match_cnt_q <= match_cnt_d;
      state_q     <= state_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      locked_q    <= locked_d;
      align_err_q <= align_err_d;
    end
  end

  assign Q         = q_q;
  assign Q_VALID   = q_valid_q;
  assign LOCKED    = locked_q;
  assign ALIGN_ERR = align_err_q;

endmodule

// File: tb/tb_i_serdes_word_aligner.sv
// Self-checking bench for i_serdes_word_aligner: directed training scenarios plus
// random traffic, compared against a bit-index boundary model.
module tb_i_serdes_word_aligner;

  localparam int         W   = 4;
  localparam logic [3:0] PAT = 4'b0011;
  localparam int         LC  = 4;

  logic       PLL_CLK = 1'b0;
  logic       RST, D, D_EN, ALIGN_EN, RELOCK;
  logic [3:0] Q;
  logic       Q_VALID, LOCKED, ALIGN_ERR;

  i_serdes_word_aligner #(.WIDTH(W), .TRAIN_PATTERN(PAT), .LOCK_COUNT(LC)) dut (
    .PLL_CLK(PLL_CLK), .RST(RST), .D(D), .D_EN(D_EN), .ALIGN_EN(ALIGN_EN),
    .RELOCK(RELOCK), .Q(Q), .Q_VALID(Q_VALID), .LOCKED(LOCKED), .ALIGN_ERR(ALIGN_ERR)
  );

  always #5 PLL_CLK = ~PLL_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: word boundaries are tracked as absolute indices into the
  // stream of valid bits; a slip pushes the next boundary one bit further out.
  logic       bq[$];
  int         next_end;
  bit         slip_owed;
  int         m_match, m_slips;
  bit         m_locked;
  logic [3:0] e_q;
  bit         e_qv, e_err;

  function automatic void model_reset();
    bq.delete();
    next_end  = W - 1;
    slip_owed = 0;
    m_match   = 0;
    m_slips   = 0;
    m_locked  = 0;
    e_q       = '0;
    e_qv      = 0;
    e_err     = 0;
  endfunction

  function automatic void model_step(bit d, bit den, bit aen, bit rl);
    logic [3:0] word;
    int idx;
    e_qv  = 0;
    e_err = 0;
    if (den) begin
      bq.push_back(d);
      idx = bq.size() - 1;
      slip_owed = 0;
      if (idx == next_end) begin
        for (int i = 0; i < W; i++) word[W-1-i] = bq[idx-W+1+i];
        e_q  = word;
        e_qv = 1;
        next_end += W;
        if (aen && !rl && !m_locked) begin
          if (word == PAT) begin
            if (m_match == 0) m_slips = 0;
            m_match++;
            if (m_match >= LC) m_locked = 1;
          end else begin
            if (m_match > 0) begin
              m_match = 0;
              m_slips = 1;
            end else begin
              m_slips++;
              if (m_slips == W) begin
                e_err   = 1;
                m_slips = 0;
              end
            end
            next_end += 1;
            slip_owed = 1;
          end
        end
      end
    end
    if (rl) begin
      if (slip_owed) begin
        next_end -= 1;
        slip_owed = 0;
      end
      m_match  = 0;
      m_slips  = 0;
      m_locked = 0;
    end
  endfunction

  int         cyc;
  int         qv_cnt, err_cnt, lock_word, first_match_word;
  int         qv_cyc[$];
  logic [3:0] q_hist[$];
  int         err_words[$];

  task automatic clear_stats();
    qv_cnt = 0; err_cnt = 0; lock_word = 0; first_match_word = 0;
    qv_cyc.delete(); q_hist.delete(); err_words.delete();
  endtask

  task automatic step(input bit d, input bit den, input bit aen, input bit rl);
    D = d; D_EN = den; ALIGN_EN = aen; RELOCK = rl;
    model_step(d, den, aen, rl);
    @(posedge PLL_CLK);
    #1;
    cyc++;
    chk("q_valid", {31'd0, Q_VALID}, {31'd0, e_qv});
    chk("align_err", {31'd0, ALIGN_ERR}, {31'd0, e_err});
    chk("locked", {31'd0, LOCKED}, {31'd0, m_locked});
    chk("q", {28'd0, Q}, {28'd0, e_q});
    if (Q_VALID) begin
      qv_cnt++;
      qv_cyc.push_back(cyc);
      q_hist.push_back(Q);
      if (Q == PAT && first_match_word == 0) first_match_word = qv_cnt;
    end
    if (ALIGN_ERR) begin
      err_cnt++;
      err_words.push_back(qv_cnt);
    end
    if (LOCKED && lock_word == 0) lock_word = qv_cnt;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b0;
    for (int i = 0; i < n; i++) begin
      D = 1'($urandom); D_EN = 1'($urandom); ALIGN_EN = 1'($urandom); RELOCK = 1'b0;
      @(posedge PLL_CLK);
      #1;
      chk("rst_q", {28'd0, Q}, 32'd0);
      chk("rst_qv", {31'd0, Q_VALID}, 32'd0);
      chk("rst_locked", {31'd0, LOCKED}, 32'd0);
      chk("rst_err", {31'd0, ALIGN_ERR}, 32'd0);
    end
    model_reset();
    RST = 1'b1;
    clear_stats();
  endtask

  task automatic send_word(input logic [3:0] w, input bit aen, input bit rl_last);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, aen, rl_last && (i == 0));
  endtask

  initial begin
    logic [3:0] sent[$];
    logic [3:0] w;
    int         pidx;
    cyc = 0;
    D = 0; D_EN = 0; ALIGN_EN = 0; RELOCK = 0; RST = 0;
    model_reset();
    clear_stats();

    // 1: reset and first-word latency
    do_reset(10);
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("t1_no_early_qv", qv_cnt, 0);
    step(1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("t1_qv_on_4th", qv_cnt, 1);

    // 2: aligned training
    do_reset(2);
    for (int i = 0; i < 6; i++) send_word(PAT, 1'b1, 1'b0);
    chk("t2_lock_word", lock_word, 4);
    chk("t2_errs", err_cnt, 0);
    chk("t2_words", qv_cnt, 6);
    for (int i = 1; i < qv_cyc.size(); i++) chk("t2_period", qv_cyc[i] - qv_cyc[i-1], 4);

    // 3: offset training, k prefix bits
    for (int k = 1; k <= 3; k++) begin
      do_reset(2);
      for (int i = 0; i < k; i++) step((k == 1) ? 1'b1 : 1'($urandom), 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) send_word(PAT, 1'b1, 1'b0);
      chk("t3_slips", first_match_word - 1, k);
      chk("t3_lock_word", lock_word, k + 4);
      if (k == 1) begin
        chk("t3_first_q", {28'd0, q_hist[0]}, 32'h9);
        chk("t3_gap", qv_cyc[1] - qv_cyc[0], 5);
      end
    end

    // 4: no pattern present
    do_reset(2);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_err_cnt", err_cnt, 3);
    if (err_words.size() == 3) begin
      chk("t4_err_w0", err_words[0], 4);
      chk("t4_err_w1", err_words[1], 8);
      chk("t4_err_w2", err_words[2], 12);
    end
    chk("t4_locked", {31'd0, LOCKED}, 32'd0);

    // 5: gapped bits while locked
    do_reset(2);
    for (int i = 0; i < 4; i++) send_word(PAT, 1'b1, 1'b0);
    chk("t5_locked", {31'd0, LOCKED}, 32'd1);
    clear_stats();
    sent.delete();
    for (int n = 0; n < 16; n++) begin
      w = 4'($urandom);
      sent.push_back(w);
      for (int b = W - 1; b >= 0; b--) begin
        for (int g = $urandom_range(3, 0); g > 0; g--) step(1'($urandom), 1'b0, 1'b1, 1'b0);
        step(w[b], 1'b1, 1'b1, 1'b0);
      end
    end
    chk("t5_words", q_hist.size(), 16);
    for (int n = 0; n < 16 && n < q_hist.size(); n++) chk("t5_word", {28'd0, q_hist[n]}, {28'd0, sent[n]});

    // 6: relock coincident with word end, then re-train
    send_word(PAT, 1'b1, 1'b1);
    chk("t6_relock_qv", {31'd0, Q_VALID}, 32'd1);
    chk("t6_locked_drop", {31'd0, LOCKED}, 32'd0);
    clear_stats();
    for (int i = 0; i < 4; i++) send_word(PAT, 1'b1, 1'b0);
    chk("t6_relock_word", lock_word, 4);

    // random traffic with a pattern-biased bit source
    pidx = 0;
    for (int i = 0; i < 600; i++) begin
      bit d, den;
      den = ($urandom_range(3, 0) != 0);
      d = ($urandom_range(1, 0) != 0) ? PAT[3 - (pidx % 4)] : 1'($urandom);
      if (den) pidx++;
      step(d, den, ($urandom_range(9, 0) != 0), ($urandom_range(49, 0) == 0));
    end

    // mid-word asynchronous reset
    do_reset(2);
    for (int i = 0; i < 5; i++) send_word(PAT, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    #2 RST = 1'b0;
    #1;
    chk("t6_arst_q", {28'd0, Q}, 32'd0);
    chk("t6_arst_locked", {31'd0, LOCKED}, 32'd0);
    chk("t6_arst_qv", {31'd0, Q_VALID}, 32'd0);
    chk("t6_arst_err", {31'd0, ALIGN_ERR}, 32'd0);
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_post_rst_no_qv", qv_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
